// File: rtl/conv_addr_pkg.sv
// Shared types and geometry helpers for the sliding-window read-address generator.
package conv_addr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Layer geometries served by the generator: image edge, kernel, stride, lanes.
    localparam int CONV1_IMG    = 28;
    localparam int CONV1_K      = 5;
    localparam int CONV1_STRIDE = 1;
    localparam int CONV1_LANES  = 4;

    localparam int CONV2_IMG    = 12;
    localparam int CONV2_K      = 5;
    localparam int CONV2_STRIDE = 1;
    localparam int CONV2_LANES  = 2;

    function automatic int out_dim(input int img, input int k, input int stride);
        return (img - k) / stride + 1;
    endfunction

    function automatic int lane_ofs(input int img_w, input int img_h, input int k,
                                    input int stride, input int lanes);
        return (out_dim(img_h, k, stride) / lanes) * stride * img_w;
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_window_counter.sv
// kc -> kr -> ox -> oy counter cascade with wrap flags and registered tap/last outputs.
module conv_window_counter
    import conv_addr_pkg::*;
#(
    parameter int K       = 5,
    parameter int OUT_W   = 24,
    parameter int ROWS_PL = 6,
    parameter int TAP_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             step,
    output logic             kc_wrap,
    output logic             kr_wrap,
    output logic             ox_wrap,
    output logic             oy_wrap,
    output logic [TAP_W-1:0] tap_idx,
    output logic             last_tap,
    output logic             last
);

    localparam int KC_W = cnt_w(K);
    localparam int OX_W = cnt_w(OUT_W);
    localparam int OY_W = cnt_w(ROWS_PL);

    localparam logic [KC_W-1:0]  K_MAX  = KC_W'(K - 1);
    localparam logic [OX_W-1:0]  OX_MAX = OX_W'(OUT_W - 1);
    localparam logic [OY_W-1:0]  OY_MAX = OY_W'(ROWS_PL - 1);
    localparam logic [TAP_W-1:0] TAP_ONE = TAP_W'(1);

    logic [KC_W-1:0]  kc_q, kc_d, kr_q, kr_d;
    logic [OX_W-1:0]  ox_q, ox_d;
    logic [OY_W-1:0]  oy_q, oy_d;
    logic [TAP_W-1:0] tap_q, tap_d;
    logic             last_tap_q, last_tap_d;
    logic             last_q, last_d;

    assign kc_wrap  = (kc_q == K_MAX);
    assign kr_wrap  = (kr_q == K_MAX);
    assign ox_wrap  = (ox_q == OX_MAX);
    assign oy_wrap  = (oy_q == OY_MAX);
    assign tap_idx  = tap_q;
    assign last_tap = last_tap_q;
    assign last     = last_q;

    always_comb begin
        kc_d       = kc_q;
        kr_d       = kr_q;
        ox_d       = ox_q;
        oy_d       = oy_q;
        tap_d      = tap_q;
        last_tap_d = last_tap_q;
        last_d     = last_q;
        if (clear) begin
            kc_d  = '0;
            kr_d  = '0;
            ox_d  = '0;
            oy_d  = '0;
            tap_d = '0;
        end else if (step) begin
            tap_d = last_tap_q ? '0 : tap_q + TAP_ONE;
            if (!kc_wrap) begin
                kc_d = kc_q + KC_W'(1);
            end else begin
                kc_d = '0;
                if (!kr_wrap) begin
                    kr_d = kr_q + KC_W'(1);
                end else begin
                    kr_d = '0;
                    if (!ox_wrap) begin
                        ox_d = ox_q + OX_W'(1);
                    end else begin
                        ox_d = '0;
                        oy_d = oy_wrap ? '0 : oy_q + OY_W'(1);
                    end
                end
            end
        end
        // Flags are derived from the next counter values so they line up with the registered beat.
        if (clear || step) begin
            last_tap_d = (kr_d == K_MAX) && (kc_d == K_MAX);
            last_d     = last_tap_d && (ox_d == OX_MAX) && (oy_d == OY_MAX);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kc_q       <= '0;
            kr_q       <= '0;
            ox_q       <= '0;
            oy_q       <= '0;
            tap_q      <= '0;
            last_tap_q <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            kc_q       <= kc_d;
            kr_q       <= kr_d;
            ox_q       <= ox_d;
            oy_q       <= oy_d;
            tap_q      <= tap_d;
            last_tap_q <= last_tap_d;
            last_q     <= last_d;
        end
    end

endmodule

// File: rtl/conv_window_addr_gen.sv
// KxK sliding-window read-address generator, LANES lockstep streams over horizontal bands.
// Optional write-address outputs (waddr, waddr_valid) are built when CONV_ADDR_GEN_WADDR_EN is defined.
module conv_window_addr_gen
    import conv_addr_pkg::*;
#(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 5,
    parameter int STRIDE = 1,
    parameter int LANES  = 4,
    parameter int ADDR_W = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    output logic [LANES*ADDR_W-1:0]   addr,
    output logic                      addr_valid,
    input  logic                      addr_ready,
    output logic [$clog2(K*K)-1:0]    tap_idx,
    output logic                      last_tap,
    output logic                      last,
    output logic                      done,
`ifdef CONV_ADDR_GEN_WADDR_EN
    output logic [LANES*ADDR_W-1:0]   waddr,
    output logic                      waddr_valid,
`endif
    output state_e                    dbg_state
);

    localparam int OUT_W    = out_dim(IMG_W, K, STRIDE);
    localparam int OUT_H    = out_dim(IMG_H, K, STRIDE);
    localparam int ROWS_PL  = OUT_H / LANES;
    localparam int LANE_OFS = lane_ofs(IMG_W, IMG_H, K, STRIDE, LANES);
    localparam int TAP_W    = $clog2(K * K);

    localparam logic [ADDR_W-1:0] STEP_TAP  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] STEP_ROW  = ADDR_W'(IMG_W - (K - 1));
    // Negative step, applied as a modular add in ADDR_W bits.
    localparam logic [ADDR_W-1:0] STEP_WIN  = ADDR_W'(STRIDE - (K - 1) * IMG_W - (K - 1));
    localparam logic [ADDR_W-1:0] STEP_OROW = ADDR_W'(STRIDE * IMG_W);

    if (OUT_H % LANES != 0) begin : g_lanes_chk
        $error("conv_window_addr_gen: OUT_H must be divisible by LANES");
    end
    if ((1 << ADDR_W) < IMG_W * IMG_H) begin : g_addr_chk
        $error("conv_window_addr_gen: ADDR_W too narrow for IMG_W*IMG_H");
    end

    function automatic logic [ADDR_W-1:0] lane_base(input int l);
        return ADDR_W'(l * LANE_OFS);
    endfunction

    state_e            state_q, state_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] addr_q[LANES];
    logic [ADDR_W-1:0] addr_d[LANES];
    logic [ADDR_W-1:0] row_q[LANES];
    logic [ADDR_W-1:0] row_d[LANES];
    logic              beat, cnt_clear, cnt_step;
    logic              kc_wrap, kr_wrap, ox_wrap, oy_wrap;

    conv_window_counter #(
        .K       (K),
        .OUT_W   (OUT_W),
        .ROWS_PL (ROWS_PL),
        .TAP_W   (TAP_W)
    ) u_counter (
        .clk      (clk),
        .rst      (reset),
        .clear    (cnt_clear),
        .step     (cnt_step),
        .kc_wrap  (kc_wrap),
        .kr_wrap  (kr_wrap),
        .ox_wrap  (ox_wrap),
        .oy_wrap  (oy_wrap),
        .tap_idx  (tap_idx),
        .last_tap (last_tap),
        .last     (last)
    );

    // Handshake: a beat is addr_valid & addr_ready at a rising edge; nothing advances otherwise.
    assign beat = valid_q & addr_ready;

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        done_d    = done_q;
        addr_d    = addr_q;
        row_d     = row_q;
        cnt_clear = 1'b0;
        cnt_step  = 1'b0;
        if (start) begin
            state_d   = RUN;
            valid_d   = 1'b1;
            done_d    = 1'b0;
            cnt_clear = 1'b1;
            for (int l = 0; l < LANES; l++) begin
                addr_d[l] = lane_base(l);
                row_d[l]  = lane_base(l);
            end
        end else if (state_q == RUN && beat) begin
            cnt_step = 1'b1;
            for (int l = 0; l < LANES; l++) begin
                if (!kc_wrap) begin
                    addr_d[l] = addr_q[l] + STEP_TAP;
                end else if (!kr_wrap) begin
                    addr_d[l] = addr_q[l] + STEP_ROW;
                end else if (!ox_wrap) begin
                    addr_d[l] = addr_q[l] + STEP_WIN;
                end else if (!oy_wrap) begin
                    addr_d[l] = row_q[l] + STEP_OROW;
                    row_d[l]  = row_q[l] + STEP_OROW;
                end else begin
                    addr_d[l] = lane_base(l);
                    row_d[l]  = lane_base(l);
                end
            end
            if (last) begin
                state_d = DONE;
                valid_d = 1'b0;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                addr_q[l] <= lane_base(l);
                row_q[l]  <= lane_base(l);
            end
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
            row_q   <= row_d;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_addr_out
        assign addr[l*ADDR_W +: ADDR_W] = addr_q[l];
    end

    assign addr_valid = valid_q;
    assign done       = done_q;
    assign dbg_state  = state_q;

`ifdef CONV_ADDR_GEN_WADDR_EN
    // Output pixels are contiguous within a lane's band, so waddr just counts closed windows.
    function automatic logic [ADDR_W-1:0] wbase(input int l);
        return ADDR_W'(l * ROWS_PL * OUT_W);
    endfunction

    logic [ADDR_W-1:0] waddr_q[LANES];
    logic [ADDR_W-1:0] waddr_d[LANES];

    always_comb begin
        waddr_d = waddr_q;
        if (start) begin
            for (int l = 0; l < LANES; l++) waddr_d[l] = wbase(l);
        end else if (state_q == RUN && beat && kc_wrap && kr_wrap) begin
            for (int l = 0; l < LANES; l++) begin
                waddr_d[l] = (ox_wrap && oy_wrap) ? wbase(l) : waddr_q[l] + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int l = 0; l < LANES; l++) waddr_q[l] <= wbase(l);
        end else begin
            waddr_q <= waddr_d;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_waddr_out
        assign waddr[l*ADDR_W +: ADDR_W] = waddr_q[l];
    end
    assign waddr_valid = last_tap & valid_q;
`endif

endmodule

// File: tb/tb_conv_window_addr_gen.sv
// Bench for conv_window_addr_gen: three geometries, scoreboard of per-beat expectations.
`timescale 1ns/1ps
module tb_conv_window_addr_gen;
    import conv_addr_pkg::*;

    localparam int EW = 88;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rdy = 1'b1;
    logic rand_rdy = 1'b0;
    logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;

    int err_cnt = 0;
    int chk_cnt = 0;
    int bcnt[3];

    logic [EW-1:0] exp_q0[$];
    logic [EW-1:0] exp_q1[$];
    logic [EW-1:0] exp_q2[$];

    logic [39:0] addr0;
    logic [19:0] addr1, addr2;
    logic [4:0]  tap0, tap1;
    logic [3:0]  tap2;
    logic        v0, v1, v2, lt0, lt1, lt2, l0, l1, l2, d0, d1, d2;
    state_e      st0, st1, st2;
    logic [EW-1:0] obs0, obs1, obs2;
    logic [EW-1:0] hold0;
    logic          hold0_v = 1'b0;

    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
`ifdef CONV_ADDR_GEN_WADDR_EN
    logic [39:0] waddr0;
    logic [19:0] waddr1, waddr2;
    logic        wv0, wv1, wv2;
`endif

    conv_window_addr_gen #(
        .IMG_W(CONV1_IMG), .IMG_H(CONV1_IMG), .K(CONV1_K),
        .STRIDE(CONV1_STRIDE), .LANES(CONV1_LANES), .ADDR_W(10)
    ) u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .addr(addr0), .addr_valid(v0),
        .addr_ready(rdy), .tap_idx(tap0), .last_tap(lt0), .last(l0), .done(d0),
`ifdef CONV_ADDR_GEN_WADDR_EN
        .waddr(waddr0), .waddr_valid(wv0),
`endif
        .dbg_state(st0)
    );

    conv_window_addr_gen #(
        .IMG_W(CONV2_IMG), .IMG_H(CONV2_IMG), .K(CONV2_K),
        .STRIDE(CONV2_STRIDE), .LANES(CONV2_LANES), .ADDR_W(10)
    ) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .addr(addr1), .addr_valid(v1),
        .addr_ready(rdy), .tap_idx(tap1), .last_tap(lt1), .last(l1), .done(d1),
`ifdef CONV_ADDR_GEN_WADDR_EN
        .waddr(waddr1), .waddr_valid(wv1),
`endif
        .dbg_state(st1)
    );

    conv_window_addr_gen #(
        .IMG_W(13), .IMG_H(13), .K(3), .STRIDE(2), .LANES(2), .ADDR_W(10)
    ) u_dut2 (
        .clk(clk), .reset(reset), .start(start2), .addr(addr2), .addr_valid(v2),
        .addr_ready(rdy), .tap_idx(tap2), .last_tap(lt2), .last(l2), .done(d2),
`ifdef CONV_ADDR_GEN_WADDR_EN
        .waddr(waddr2), .waddr_valid(wv2),
`endif
        .dbg_state(st2)
    );

    // Entry layout: [39:0] lane addrs, [44:40] tap, [45] last_tap, [46] last, [86:47] waddrs, [87] waddr_valid
    function automatic logic [EW-1:0] pack_obs(input logic [39:0] a, input logic [4:0] t,
                                               input logic lt, input logic l,
                                               input logic [39:0] wa, input logic wv);
        return {wv, wa, l, lt, t, a};
    endfunction

`ifdef CONV_ADDR_GEN_WADDR_EN
    assign obs0 = pack_obs(addr0, tap0, lt0, l0, waddr0, wv0);
    assign obs1 = pack_obs(40'(addr1), tap1, lt1, l1, 40'(waddr1), wv1);
    assign obs2 = pack_obs(40'(addr2), 5'(tap2), lt2, l2, 40'(waddr2), wv2);
`else
    assign obs0 = pack_obs(addr0, tap0, lt0, l0, 40'd0, 1'b0);
    assign obs1 = pack_obs(40'(addr1), tap1, lt1, l1, 40'd0, 1'b0);
    assign obs2 = pack_obs(40'(addr2), 5'(tap2), lt2, l2, 40'd0, 1'b0);
`endif

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference model: decompose the beat index into counters and apply the closed-form address.
    function automatic logic [EW-1:0] exp_entry(input int iw, input int ih, input int k,
                                                input int s, input int ln, input int b);
        logic [EW-1:0] e;
        int ow, rpl, kk, tap, win, ox, oy, kr, kc;
        ow  = (iw - k) / s + 1;
        rpl = ((ih - k) / s + 1) / ln;
        kk  = k * k;
        tap = b % kk;
        win = b / kk;
        ox  = win % ow;
        oy  = win / ow;
        kr  = tap / k;
        kc  = tap % k;
        e   = '0;
        for (int l = 0; l < ln; l++) begin
            e[l*10 +: 10]      = 10'(l * rpl * s * iw + (oy * s + kr) * iw + ox * s + kc);
            e[47 + l*10 +: 10] = 10'(l * rpl * ow + win);
        end
        e[44:40] = 5'(tap);
        e[45]    = (tap == kk - 1);
        e[46]    = (tap == kk - 1) && (win == ow * rpl - 1);
        e[87]    = (tap == kk - 1);
        return e;
    endfunction

    task automatic push_sweep(input int sel);
        int iw, ih, k, s, ln, beats;
        case (sel)
            0: begin iw = 28; ih = 28; k = 5; s = 1; ln = 4; end
            1: begin iw = 12; ih = 12; k = 5; s = 1; ln = 2; end
            default: begin iw = 13; ih = 13; k = 3; s = 2; ln = 2; end
        endcase
        beats = (((ih - k) / s + 1) / ln) * ((iw - k) / s + 1) * k * k;
        case (sel)
            0: exp_q0.delete();
            1: exp_q1.delete();
            default: exp_q2.delete();
        endcase
        for (int b = 0; b < beats; b++) begin
            case (sel)
                0: exp_q0.push_back(exp_entry(iw, ih, k, s, ln, b));
                1: exp_q1.push_back(exp_entry(iw, ih, k, s, ln, b));
                default: exp_q2.push_back(exp_entry(iw, ih, k, s, ln, b));
            endcase
        end
    endtask

    function automatic int q_size(input int sel);
        return (sel == 0) ? exp_q0.size() : ((sel == 1) ? exp_q1.size() : exp_q2.size());
    endfunction

    task automatic mon_beat(input int sel, input logic [EW-1:0] obs);
        logic [EW-1:0] e;
        int b;
        b = bcnt[sel];
        if (q_size(sel) == 0) begin
            check_val($sformatf("g%0d_beat%0d_expected", sel, b), EW'(q_size(sel) > 0), EW'(1));
            bcnt[sel]++;
            return;
        end
        case (sel)
            0: e = exp_q0.pop_front();
            1: e = exp_q1.pop_front();
            default: e = exp_q2.pop_front();
        endcase
`ifndef CONV_ADDR_GEN_WADDR_EN
        e[EW-1:47] = '0;
`endif
        check_val($sformatf("g%0d_beat%0d", sel, b), obs, e);
        if (sel == 0 && b == 0)    check_val("g0_bases", EW'(obs[39:0]), EW'({10'd504, 10'd336, 10'd168, 10'd0}));
        if (sel == 0 && b == 5)    check_val("g0_beat5_lane0", EW'(obs[9:0]), EW'(28));
        if (sel == 0 && b == 25)   check_val("g0_beat25_lane0", EW'(obs[9:0]), EW'(1));
        if (sel == 0 && b == 3599) check_val("g0_final_lane3_last", EW'({obs[46], obs[39:30]}), EW'({1'b1, 10'd783}));
`ifdef CONV_ADDR_GEN_WADDR_EN
        if (sel == 0 && b == 3599) check_val("g0_final_waddr3", EW'({obs[87], obs[86:77]}), EW'({1'b1, 10'd575}));
`endif
        if (sel == 1 && b == 0)    check_val("g1_bases", EW'(obs[19:0]), EW'({10'd48, 10'd0}));
        if (sel == 1 && b == 799)  check_val("g1_final_lane1", EW'(obs[19:10]), EW'(143));
        if (sel == 2 && b == 9)    check_val("g2_win1_lane0", EW'(obs[9:0]), EW'(2));
        if (sel == 2 && b == 161)  check_val("g2_final_lane1", EW'(obs[19:10]), EW'(168));
        bcnt[sel]++;
    endtask

    // ---------------- monitors (sampled on the falling edge) ----------------
    always @(negedge clk) begin
        if (reset) begin
            hold0_v = 1'b0;
        end else begin
            if (hold0_v) check_val("g0_stall_hold", obs0, hold0);
            hold0_v = v0 && !rdy && !start0;
            hold0   = obs0;
            if (v0 && rdy && !start0) mon_beat(0, obs0);
        end
    end

    always @(negedge clk) begin
        if (!reset && v1 && rdy && !start1) mon_beat(1, obs1);
        if (!reset && v2 && rdy && !start2) mon_beat(2, obs2);
    end

    always @(posedge clk) begin
        #1;
        if (rand_rdy) rdy = 1'($urandom_range(0, 1));
        else          rdy = 1'b1;
    end

    // ---------------- driver tasks ----------------
    function automatic logic sel_valid(input int sel);
        return (sel == 0) ? v0 : ((sel == 1) ? v1 : v2);
    endfunction

    function automatic logic sel_done(input int sel);
        return (sel == 0) ? d0 : ((sel == 1) ? d1 : d2);
    endfunction

    function automatic state_e sel_state(input int sel);
        return (sel == 0) ? st0 : ((sel == 1) ? st1 : st2);
    endfunction

    task automatic set_start(input int sel, input logic val);
        case (sel)
            0: start0 = val;
            1: start1 = val;
            default: start2 = val;
        endcase
    endtask

    task automatic start_sweep(input int sel);
        @(posedge clk);
        #1;
        push_sweep(sel);
        bcnt[sel] = 0;
        set_start(sel, 1'b1);
        @(posedge clk);
        #1;
        set_start(sel, 1'b0);
        check_val($sformatf("g%0d_start_latency", sel),
                  EW'({sel_valid(sel), sel_done(sel)}), EW'(2'b10));
    endtask

    task automatic wait_beats(input int sel, input int n);
        int c;
        c = 0;
        while (bcnt[sel] < n && c < 20000) begin
            @(negedge clk);
            c++;
        end
        check_val($sformatf("g%0d_reach_beat%0d", sel, n), EW'(bcnt[sel] >= n), EW'(1));
    endtask

    task automatic wait_done(input int sel, input int beats);
        int c;
        c = 0;
        while (sel_done(sel) !== 1'b1 && c < 20000) begin
            @(negedge clk);
            c++;
        end
        check_val($sformatf("g%0d_done", sel), EW'(sel_done(sel)), EW'(1));
        check_val($sformatf("g%0d_beat_count", sel), EW'(bcnt[sel]), EW'(beats));
        check_val($sformatf("g%0d_queue_drained", sel), EW'(q_size(sel)), EW'(0));
        check_val($sformatf("g%0d_done_state", sel), EW'(sel_state(sel)), EW'(DONE));
        repeat (3) @(negedge clk);
        check_val($sformatf("g%0d_done_sticky", sel),
                  EW'({sel_done(sel), sel_valid(sel)}), EW'(2'b10));
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, "_g0_addr"}, EW'(addr0), EW'({10'd504, 10'd336, 10'd168, 10'd0}));
        check_val({tag, "_g1_addr"}, EW'(addr1), EW'({10'd48, 10'd0}));
        check_val({tag, "_g2_addr"}, EW'(addr2), EW'({10'd78, 10'd0}));
        check_val({tag, "_g0_flags"}, EW'({v0, d0, lt0, l0, tap0}), EW'(0));
        check_val({tag, "_g1_flags"}, EW'({v1, d1, lt1, l1, tap1}), EW'(0));
        check_val({tag, "_g2_flags"}, EW'({v2, d2, lt2, l2, tap2}), EW'(0));
        check_val({tag, "_states"}, EW'({st0, st1, st2}), EW'({IDLE, IDLE, IDLE}));
`ifdef CONV_ADDR_GEN_WADDR_EN
        check_val({tag, "_g0_waddr"}, EW'({wv0, waddr0}), EW'({1'b0, 10'd432, 10'd288, 10'd144, 10'd0}));
        check_val({tag, "_g1_waddr"}, EW'({wv1, waddr1}), EW'({1'b0, 10'd32, 10'd0}));
        check_val({tag, "_g2_waddr"}, EW'({wv2, waddr2}), EW'({1'b0, 10'd18, 10'd0}));
`endif
    endtask

    // ---------------- sequence ----------------
    initial begin
        for (int i = 0; i < 3; i++) bcnt[i] = 0;
        repeat (3) @(negedge clk);
        check_reset("rst");
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_val("idle_no_valid", EW'({v0, v1, v2}), EW'(0));

        // full sweep with ready held high
        start_sweep(0);
        wait_done(0, 3600);

        // full sweep with random back-pressure
        rand_rdy = 1'b1;
        start_sweep(0);
        wait_done(0, 3600);
        rand_rdy = 1'b0;

        // restart mid-sweep
        start_sweep(0);
        wait_beats(0, 1000);
        start_sweep(0);
        wait_done(0, 3600);

        // asynchronous reset mid-sweep
        start_sweep(0);
        wait_beats(0, 500);
        #2;
        reset = 1'b1;
        exp_q0.delete();
        #1;
        check_reset("midrst");
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check_val("midrst_no_resume", EW'({v0, d0, st0}), EW'({1'b0, 1'b0, IDLE}));

        // smaller geometries
        start_sweep(1);
        wait_done(1, 800);
        start_sweep(2);
        wait_done(2, 162);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", err_cnt, chk_cnt);
        $fatal(1, "watchdog");
    end

endmodule
